// File: rtl/guess_input_conditioner.sv
// Front end for guess_game: synchronises, debounces and qualifies raw guess switches
// into a single-cycle one-hot G pulse, flagging simultaneous multi-switch presses.
//
// state   | meaning
// --------+-------------------------------------------------------------
// STARTUP | post-reset wait while the debouncers fill from the inputs
// IDLE    | no debounced switch active, waiting for a press
// SETTLE  | press seen, letting late neighbours settle before evaluation
// HOLD    | outcome issued; waiting for full release of every switch
module guess_input_conditioner #(
    parameter int WIDTH         = 10,
    parameter int DB_CYCLES     = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] G,
    output logic             g_valid,
    output logic             multi_err,
    output logic             busy
);

    localparam int TMR_MAX = (DB_CYCLES + 3 > SETTLE_CYCLES) ? DB_CYCLES + 3 : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        STARTUP = 2'd0,
        IDLE    = 2'd1,
        SETTLE  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    logic [WIDTH-1:0]            s1, s2, stab;
    logic [WIDTH-1:0][CNT_W-1:0] db_cnt;
    logic                        db_idle;
    logic                        stab_onehot;

    state_t           state, state_nx;
    logic [TMR_W-1:0] tmr, tmr_nx;
    logic [WIDTH-1:0] g_nx;
    logic             gv_nx, me_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1     <= '0;
            s2     <= '0;
            stab   <= '0;
            db_cnt <= '0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
            for (int i = 0; i < WIDTH; i++) begin
                if (s2[i] == stab[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DB_CYCLES - 1)) begin
                    stab[i]   <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign db_idle     = (db_cnt == '0);
    assign stab_onehot = (stab != '0) && ((stab & (stab - WIDTH'(1))) == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= STARTUP;
            tmr       <= '0;
            G         <= '0;
            g_valid   <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            state     <= state_nx;
            tmr       <= tmr_nx;
            G         <= g_nx;
            g_valid   <= gv_nx;
            multi_err <= me_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        g_nx     = '0;
        gv_nx    = 1'b0;
        me_nx    = 1'b0;
        case (state)
            STARTUP: begin
                if (tmr == TMR_W'(DB_CYCLES + 2)) begin
                    state_nx = HOLD;
                    tmr_nx   = '0;
                end else begin
                    tmr_nx = tmr + TMR_W'(1);
                end
            end
            IDLE: begin
                if (stab != '0) begin
                    state_nx = SETTLE;
                    tmr_nx   = '0;
                end
            end
            SETTLE: begin
                if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
                    tmr_nx = '0;
                    if (stab_onehot) begin
                        g_nx     = stab;
                        gv_nx    = 1'b1;
                        state_nx = HOLD;
                    end else if (stab != '0) begin
                        me_nx    = 1'b1;
                        state_nx = HOLD;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    tmr_nx = tmr + TMR_W'(1);
                end
            end
            HOLD: begin
                // wait for the debouncers to go quiet too, so a bounce cannot re-trigger
                if (stab == '0 && db_idle) state_nx = IDLE;
            end
            default: state_nx = STARTUP;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_guess_input_conditioner.sv
// Randomised scoreboard bench for guess_input_conditioner: each press episode predicts
// its outcome (pulse value and edge) from the latency rule; a monitor checks DUT outputs.
module tb_guess_input_conditioner;

    localparam int W   = 10;
    localparam int LAT = 4 + 2 + 2;  // DB_CYCLES + SETTLE_CYCLES + 2

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] G;
    logic         g_valid, multi_err, busy;

    typedef struct {
        int           at_edge;
        logic [W-1:0] g;
        logic         err;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    guess_input_conditioner #(
        .WIDTH(W), .DB_CYCLES(4), .SETTLE_CYCLES(2), .CNT_W(3)
    ) dut (
        .clk(clk), .reset(reset), .sw_raw(sw_raw),
        .G(G), .g_valid(g_valid), .multi_err(multi_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge just before raw goes active: the next rising edge samples it.
    task automatic expect_at(input logic [W-1:0] g, input logic err);
        exp_t e;
        e.at_edge = cyc + 1 + LAT;
        e.g       = g;
        e.err     = err;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            while (q.size() > 0 && q[0].at_edge < cyc) begin
                exp_t m;
                m = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_out actual=none required G=%b err=%0b at edge %0d",
                         m.g, m.err, m.at_edge);
            end
            if (g_valid || multi_err || G != '0) begin
                checks++;
                if (g_valid && multi_err) begin
                    errors++;
                    $display("FAIL excl_out actual g_valid=1 multi_err=1 required not both");
                end
                checks++;
                if (g_valid != (G != '0) || (G & (G - 1'b1)) != '0) begin
                    errors++;
                    $display("FAIL g_shape actual G=%b g_valid=%0b required one-hot with valid",
                             G, g_valid);
                end
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual G=%b err=%0b required none at edge %0d",
                             G, multi_err, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    checks++;
                    if (e.at_edge != cyc || e.g != G || e.err != multi_err) begin
                        errors++;
                        $display("FAIL out_match actual G=%b err=%0b edge=%0d required G=%b err=%0b edge=%0d",
                                 G, multi_err, cyc, e.g, e.err, e.at_edge);
                    end
                end
            end
        end
    end

    initial begin
        int           b, b2, h, d, kind;
        logic [W-1:0] m;

        reset  = 1'b0;
        sw_raw = '0;
        #1;
        chk("rst_G", 32'(G), 32'd0);
        chk("rst_gvalid", 32'(g_valid), 32'd0);
        chk("rst_merr", 32'(multi_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        tick(20);
        chk("startup_busy", 32'(busy), 32'd0);

        // MSB press held 12 cycles
        expect_at(10'b1000000000, 1'b0);
        sw_raw = 10'b1000000000;
        tick(12);
        sw_raw = '0;
        tick(20);
        chk("msb_busy", 32'(busy), 32'd0);

        // 3-cycle glitch on bit0
        sw_raw = 10'b0000000001;
        tick(3);
        sw_raw = '0;
        tick(3);
        chk("glitch_busy", 32'(busy), 32'd0);
        tick(10);

        // staggered double press, then bit1 alone
        expect_at('0, 1'b1);
        sw_raw = 10'b0000000010;
        tick(1);
        sw_raw = 10'b0000000110;
        tick(12);
        sw_raw = '0;
        tick(20);
        expect_at(10'b0000000010, 1'b0);
        sw_raw = 10'b0000000010;
        tick(10);
        sw_raw = '0;
        tick(20);

        // bit0 held through reset must be released before it counts
        reset  = 1'b0;
        sw_raw = 10'b0000000001;
        @(negedge clk);
        reset = 1'b1;
        tick(25);
        chk("held_busy", 32'(busy), 32'd1);
        sw_raw = '0;
        tick(20);
        chk("held_rel_busy", 32'(busy), 32'd0);
        expect_at(10'b0000000001, 1'b0);
        sw_raw = 10'b0000000001;
        tick(10);
        sw_raw = '0;
        tick(20);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            b    = $urandom_range(0, W - 1);
            if (kind == 0) begin
                h = $urandom_range(6, 15);
                m = '0;
                m[b] = 1'b1;
                expect_at(m, 1'b0);
                sw_raw = m;
                tick(h);
            end else if (kind == 1) begin
                h = $urandom_range(1, 3);
                m = '0;
                m[b] = 1'b1;
                sw_raw = m;
                tick(h);
            end else begin
                b2 = (b + $urandom_range(1, W - 1)) % W;
                d  = $urandom_range(0, 2);
                m  = '0;
                m[b] = 1'b1;
                expect_at('0, 1'b1);
                if (d == 0) m[b2] = 1'b1;
                sw_raw = m;
                tick(d);
                m[b2] = 1'b1;
                sw_raw = m;
                tick(12);
            end
            sw_raw = '0;
            tick(20);
            chk("rand_busy", 32'(busy), 32'd0);
        end

        // reset lands in the G cycle
        expect_at(10'b0000000010, 1'b0);
        sw_raw = 10'b0000000010;
        tick(LAT + 1);
        #2;
        chk("pre_rst_G", 32'(G), 32'h2);
        reset = 1'b0;
        #1;
        chk("midrst_G", 32'(G), 32'd0);
        chk("midrst_gvalid", 32'(g_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        sw_raw = '0;
        @(negedge clk);
        reset = 1'b1;
        tick(25);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
